logo_motion_ctrl: RTL and testbench

Frame-synchronous motion scheduler for the bouncing-logo display path. It watches the VGA timing generator's `vsync` and advances the logo position once every `speed+1` frames. Each advance is `step` pixels diagonally, with reflection at the screen edges. `logo_x`/`logo_y` change only right after the vsync falling edge, during vertical blanking, so the pixel/ROM fetch path always sees a stable position for a whole active frame. It feeds `logo_x`/`logo_y` to the logo-area compare and ROM address logic.

---
 rtl/logo_motion_ctrl_if.sv | 24 ++
 rtl/logo_motion_ctrl.sv | 150 +++++++++++++++
 tb/tb_logo_motion_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logo_motion_ctrl_if.sv
// Bus between the VGA timing/control side and the logo motion scheduler.
// The timing side (master) drives vsync and motion controls; the scheduler (slave) returns position and event pulses.
interface logo_motion_ctrl_if;
  logic       vsync;
  logic [3:0] speed;
  logic [2:0] step;
  logic       pause;
  logic [9:0] logo_x;
  logic [9:0] logo_y;
  logic [1:0] dir;
  logic       update_done;
  logic       bounce;
  logic       corner;

  modport master (
    output vsync, speed, step, pause,
    input  logo_x, logo_y, dir, update_done, bounce, corner
  );

  modport slave (
    input  vsync, speed, step, pause,
    output logo_x, logo_y, dir, update_done, bounce, corner
  );
endinterface

// File: rtl/logo_motion_ctrl.sv
// Frame-synchronous bouncing-logo position scheduler: moves the logo diagonally once every speed+1 frames,
// reflecting at the screen edges, and commits the new position only just after the vsync falling edge.
module logo_motion_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int LOGO_W = 100,
  parameter int LOGO_H = 100,
  parameter int X_INIT = 100,
  parameter int Y_INIT = 100
) (
  input  logic pclk,
  input  logic rst_n,
  logo_motion_ctrl_if.slave bus
);

  localparam logic [10:0] XMAX = 11'(H_RES - LOGO_W);
  localparam logic [10:0] YMAX = 11'(V_RES - LOGO_H);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC_X = 2'd1;
  localparam logic [1:0] S_CALC_Y = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  logic       r_vs_d;
  logic [1:0] r_state;
  logic [3:0] r_frame_cnt;
  logic [3:0] r_spd_s;
  logic [2:0] r_stp_s;
  logic [9:0] r_nx;
  logic [9:0] r_ny;
  logic [1:0] r_ndir;
  logic [1:0] r_flip;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [1:0] r_dir;
  logic       r_update_done;
  logic       r_bounce;
  logic       r_corner;

  logic        w_frame_evt;
  logic [9:0]  w_pos [2];
  logic [10:0] w_max [2];
  // Per axis: {flipped, new direction, new position}; index 1 = x, 0 = y (matches dir bit order).
  logic [11:0] w_axis [2];

  assign w_frame_evt = r_vs_d & ~bus.vsync;

  assign w_pos[1] = r_x;
  assign w_pos[0] = r_y;
  assign w_max[1] = XMAX;
  assign w_max[0] = YMAX;

  // 11-bit arithmetic so x+step never wraps before it is compared against the edge.
  function automatic logic [11:0] f_axis(input logic [9:0] pos, input logic [2:0] stp,
                                         input logic dec, input logic [10:0] maxv);
    logic [10:0] sum;
    logic [10:0] pos_w;
    logic [10:0] stp_w;
    logic [11:0] res;
    pos_w = {1'b0, pos};
    stp_w = {8'd0, stp};
    sum   = pos_w + stp_w;
    res   = {1'b0, dec, pos};
    if (stp != 3'd0) begin
      if (!dec) begin
        if (sum >= maxv) res = {1'b1, 1'b1, maxv[9:0]};
        else             res = {1'b0, 1'b0, sum[9:0]};
      end else begin
        if (pos_w <= stp_w) res = {1'b1, 1'b0, 10'd0};
        else                res = {1'b0, 1'b1, pos - {7'd0, stp}};
      end
    end
    return res;
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      assign w_axis[gi] = f_axis(w_pos[gi], r_stp_s, r_dir[gi], w_max[gi]);
    end
  endgenerate

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d        <= 1'b1;
      r_state       <= S_IDLE;
      r_frame_cnt   <= 4'd0;
      r_spd_s       <= 4'd0;
      r_stp_s       <= 3'd0;
      r_nx          <= 10'(X_INIT);
      r_ny          <= 10'(Y_INIT);
      r_ndir        <= 2'b01;
      r_flip        <= 2'b00;
      r_x           <= 10'(X_INIT);
      r_y           <= 10'(Y_INIT);
      r_dir         <= 2'b01;
      r_update_done <= 1'b0;
      r_bounce      <= 1'b0;
      r_corner      <= 1'b0;
    end else begin
      r_vs_d        <= bus.vsync;
      r_update_done <= 1'b0;
      r_bounce      <= 1'b0;
      r_corner      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Frame events are only honoured here; pause freezes the divider too.
          if (w_frame_evt && !bus.pause) begin
            if (r_frame_cnt == r_spd_s) begin
              r_frame_cnt <= 4'd0;
              r_spd_s     <= bus.speed;
              r_stp_s     <= bus.step;
              r_state     <= S_CALC_X;
            end else begin
              r_frame_cnt <= r_frame_cnt + 4'd1;
            end
          end
        end
        S_CALC_X: begin
          r_flip[1] <= w_axis[1][11];
          r_ndir[1] <= w_axis[1][10];
          r_nx      <= w_axis[1][9:0];
          r_state   <= S_CALC_Y;
        end
        S_CALC_Y: begin
          r_flip[0] <= w_axis[0][11];
          r_ndir[0] <= w_axis[0][10];
          r_ny      <= w_axis[0][9:0];
          r_state   <= S_COMMIT;
        end
        default: begin
          r_x           <= r_nx;
          r_y           <= r_ny;
          r_dir         <= r_ndir;
          r_update_done <= 1'b1;
          r_bounce      <= |r_flip;
          r_corner      <= &r_flip;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.logo_x      = r_x;
  assign bus.logo_y      = r_y;
  assign bus.dir         = r_dir;
  assign bus.update_done = r_update_done;
  assign bus.bounce      = r_bounce;
  assign bus.corner      = r_corner;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Scoreboard bench for logo_motion_ctrl: each vsync fall that should cause a move pushes the expected
// position/pulses; a negedge monitor pops and compares whenever update_done is seen.
module tb_logo_motion_ctrl;

  logic pclk;
  logic rst_n;
  longint cyc;

  logo_motion_ctrl_if bus();
  logo_motion_ctrl_if bus_c();

  logo_motion_ctrl u_dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logo_motion_ctrl #(.X_INIT(539), .Y_INIT(1)) u_dut_c (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int         x;
    int         y;
    logic [1:0] d;
    logic       b;
    logic       c;
    longint     cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_err;
  int   n_pulse;
  logic last_b;
  logic last_c;

  int         mx, my, mfc, mspd;
  logic [1:0] md;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 100; my = 100; md = 2'b01; mfc = 0; mspd = 0;
    q.delete();
  endtask

  task automatic axis(input int p, input int s, input logic dec, input int lim,
                      output int np, output logic nd, output logic fl);
    np = p; nd = dec; fl = 1'b0;
    if (s != 0) begin
      if (!dec) begin
        if (p + s >= lim) begin np = lim; nd = 1'b1; fl = 1'b1; end
        else np = p + s;
      end else begin
        if (p <= s) begin np = 0; nd = 1'b0; fl = 1'b1; end
        else np = p - s;
      end
    end
  endtask

  // One vsync low pulse; the model decides whether this frame produces a move.
  task automatic fall();
    exp_t e;
    logic fx, fy, dx, dy;
    int   nx, ny;
    @(posedge pclk); #1;
    bus.vsync = 1'b0;
    if (!bus.pause) begin
      if (mfc == mspd) begin
        mfc  = 0;
        mspd = int'(bus.speed);
        axis(mx, int'(bus.step), md[1], 540, nx, dx, fx);
        axis(my, int'(bus.step), md[0], 380, ny, dy, fy);
        mx = nx; my = ny; md = {dx, dy};
        e.x = nx; e.y = ny; e.d = md; e.b = fx | fy; e.c = fx & fy; e.cyc = cyc;
        q.push_back(e);
      end else begin
        mfc++;
      end
    end
    repeat (2) @(posedge pclk);
    #1 bus.vsync = 1'b1;
    repeat (7) @(posedge pclk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  always @(negedge pclk) begin
    if (rst_n) begin
      if (bus.update_done) begin
        n_pulse++;
        last_b = bus.bounce;
        last_c = bus.corner;
        if (q.size() == 0) begin
          chk("spurious_update", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("x", bus.logo_x, e.x);
          chk("y", bus.logo_y, e.y);
          chk("dir", bus.dir, e.d);
          chk("bounce", bus.bounce, e.b);
          chk("corner", bus.corner, e.c);
          chk("latency", 32'(cyc), 32'(e.cyc + 4));
          $display("move: x=%0d y=%0d dir=%b bounce=%b corner=%b", bus.logo_x, bus.logo_y,
                   bus.dir, bus.bounce, bus.corner);
        end
      end else if (bus.bounce || bus.corner) begin
        chk("stray_pulse", {bus.bounce, bus.corner}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, x0, guard;
    n_vec = 0; n_err = 0; n_pulse = 0;
    last_b = 1'b0; last_c = 1'b0;
    rst_n = 1'b0;
    bus.vsync = 1'b1; bus.speed = 4'd0; bus.step = 3'd1; bus.pause = 1'b0;
    bus_c.vsync = 1'b1; bus_c.speed = 4'd0; bus_c.step = 3'd2; bus_c.pause = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_x", bus.logo_x, 100);
    chk("rst_y", bus.logo_y, 100);
    chk("rst_dir", bus.dir, 2'b01);
    chk("rst_upd", bus.update_done, 0);
    chk("rst_cx", bus_c.logo_x, 539);
    chk("rst_cy", bus_c.logo_y, 1);
    rst_n = 1'b1;
    repeat (2) @(posedge pclk);

    // First move: speed 0, step 1.
    fall();
    chk("first_x", bus.logo_x, 101);
    chk("first_y", bus.logo_y, 99);
    chk("first_bounce", last_b, 0);

    // Corner on the second instance.
    @(posedge pclk); #1 bus_c.vsync = 1'b0;
    guard = 0;
    do begin
      @(negedge pclk);
      guard++;
    end while (!bus_c.update_done && guard < 10);
    chk("corner_seen", bus_c.update_done, 1);
    chk("corner_x", bus_c.logo_x, 540);
    chk("corner_y", bus_c.logo_y, 0);
    chk("corner_dir", bus_c.dir, 2'b10);
    chk("corner_bounce", bus_c.bounce, 1);
    chk("corner_corner", bus_c.corner, 1);
    @(posedge pclk); #1 bus_c.vsync = 1'b1;

    // Frame divider: one move latches speed 3, then moves land on falls 4 and 8.
    bus.speed = 4'd3; bus.step = 3'd1;
    fall();
    x0 = int'(bus.logo_x);
    for (int i = 1; i <= 8; i++) begin
      p0 = n_pulse;
      fall();
      chk($sformatf("div_fall%0d", i), n_pulse - p0, (i == 4 || i == 8) ? 1 : 0);
    end
    chk("div_dx", int'(bus.logo_x) - x0, 2);

    // X reflection: walk to x=538 moving right, then step 4.
    rst_n = 1'b0;
    #1 model_reset();
    @(posedge pclk); #1 rst_n = 1'b1;
    bus.speed = 4'd0; bus.step = 3'd2;
    guard = 0;
    while (!(mx == 538 && md[1] == 1'b0) && guard < 400) begin
      fall();
      guard++;
    end
    chk("refl_pre_x", bus.logo_x, 538);
    bus.step = 3'd4;
    fall();
    chk("refl_x", bus.logo_x, 540);
    chk("refl_dir1", bus.dir[1], 1);
    chk("refl_bounce", last_b, 1);
    chk("refl_corner", last_c, 0);
    fall();
    chk("refl_next_x", bus.logo_x, 536);

    // Pause: three falls with no motion, then release.
    bus.pause = 1'b1;
    x0 = int'(bus.logo_x);
    p0 = n_pulse;
    repeat (3) fall();
    chk("pause_pulses", n_pulse - p0, 0);
    chk("pause_x", bus.logo_x, x0);
    bus.pause = 1'b0; bus.speed = 4'd0; bus.step = 3'd3;
    fall();
    chk("unpause_x", bus.logo_x, x0 - 3);

    // Reset while in CALC_Y: move abandoned, outputs back to reset values.
    p0 = n_pulse;
    @(posedge pclk); #1 bus.vsync = 1'b0;
    repeat (2) @(posedge pclk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_x", bus.logo_x, 100);
    chk("midrst_y", bus.logo_y, 100);
    chk("midrst_dir", bus.dir, 2'b01);
    chk("midrst_upd", bus.update_done, 0);
    model_reset();
    bus.vsync = 1'b1;
    repeat (4) @(posedge pclk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge pclk);
    chk("midrst_no_pulse", n_pulse - p0, 0);
    bus.step = 3'd1;
    fall();
    chk("midrst_next_x", bus.logo_x, 101);
    chk("midrst_next_y", bus.logo_y, 99);

    repeat (4) @(posedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
